rs_alu: RTL and testbench

Reservation station for the integer ALU functional unit in the out-of-order core. It accepts renamed integer-ALU micro-ops from dispatch and holds them until both physical source operands are ready. Readiness is tracked by snooping the common data bus (CDB). Each cycle it issues at most one ready entry toward the register-file read and ALU execute stage.

---
 rtl/rs_alu_pkg.sv | 24 ++
 rtl/rs_alu_if.sv | 50 +++++
 rtl/rs_alu_select.sv | 27 ++
 rtl/rs_alu.sv | 152 +++++++++++++++
 tb/tb_rs_alu.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// Shared types for the integer-ALU reservation station: decoded micro-op fields.
// Build option: RS_ALU_OLDEST_FIRST_EN selects oldest-first issue via an age matrix.
package rs_alu_pkg;

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] i_imm;
  } decode_info_t;

  function automatic int occ_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB snoop and issue bundle for rs_alu; master drives dispatch/CDB/issue_ready.
interface rs_alu_if #(
  parameter int DEPTH         = 8,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
);
  import rs_alu_pkg::*;

  localparam int OCC_BITS = occ_bits(DEPTH);

  logic                     dispatch_valid;
  logic                     dispatch_ready;
  decode_info_t             dispatch_info;
  logic [PHYS_REG_BITS-1:0] dispatch_ps1;
  logic [PHYS_REG_BITS-1:0] dispatch_ps2;
  logic                     dispatch_ps1_rdy;
  logic                     dispatch_ps2_rdy;
  logic [PHYS_REG_BITS-1:0] dispatch_pd;
  logic [ROB_IDX_BITS-1:0]  dispatch_rob;

  logic                     cdb_valid;
  logic [PHYS_REG_BITS-1:0] cdb_pd;

  logic                     issue_valid;
  logic                     issue_ready;
  decode_info_t             issue_info;
  logic [PHYS_REG_BITS-1:0] issue_ps1;
  logic [PHYS_REG_BITS-1:0] issue_ps2;
  logic [PHYS_REG_BITS-1:0] issue_pd;
  logic [ROB_IDX_BITS-1:0]  issue_rob;

  logic [OCC_BITS-1:0]      occupancy;

  modport master (
    output dispatch_valid, dispatch_info, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, dispatch_pd, dispatch_rob,
           cdb_valid, cdb_pd, issue_ready,
    input  dispatch_ready, issue_valid, issue_info, issue_ps1, issue_ps2,
           issue_pd, issue_rob, occupancy
  );

  modport slave (
    input  dispatch_valid, dispatch_info, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, dispatch_pd, dispatch_rob,
           cdb_valid, cdb_pd, issue_ready,
    output dispatch_ready, issue_valid, issue_info, issue_ps1, issue_ps2,
           issue_pd, issue_rob, occupancy
  );

endinterface

// File: rtl/rs_alu_select.sv
// Issue arbiter: one-hot grant among ready entries. Lowest index by default,
// oldest-first when RS_ALU_OLDEST_FIRST_EN is defined (age[i][j] = entry j older than i).
module rs_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] cand,
`ifdef RS_ALU_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0] age [DEPTH],
`endif
  output logic [DEPTH-1:0] grant,
  output logic             any_grant
);

`ifdef RS_ALU_OLDEST_FIRST_EN
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = cand[i] && ((age[i] & cand) == '0);
    end
  end
`else
  assign grant = cand & (~cand + DEPTH'(1));
`endif

  assign any_grant = |cand;

endmodule

// File: rtl/rs_alu.sv
// Integer-ALU reservation station: holds renamed micro-ops until both sources are
// ready (CDB snoop), issues one per cycle. RS_ALU_OLDEST_FIRST_EN enables age-ordered issue.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  rs_alu_if.slave  bus
);

  localparam int OCC_BITS = occ_bits(DEPTH);

  typedef struct packed {
    decode_info_t             info;
    logic [PHYS_REG_BITS-1:0] ps1;
    logic [PHYS_REG_BITS-1:0] ps2;
    logic                     rdy1;
    logic                     rdy2;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
  } rs_entry_t;

  rs_entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    free_oh;
  logic [DEPTH-1:0]    cand;
  logic [DEPTH-1:0]    grant;
  logic                any_grant;
  logic [OCC_BITS-1:0] occ;
  logic                dispatch_fire;
  logic                issue_fire;
  rs_entry_t           new_ent;
  rs_entry_t           sel_ent;

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_BITS'(valid_q[i]);
    end
  end

  // Lowest-index free slot; never empty when dispatch fires.
  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign bus.dispatch_ready = ~(&valid_q);
  assign bus.occupancy      = occ;
  assign dispatch_fire      = bus.dispatch_valid && bus.dispatch_ready;
  assign issue_fire         = any_grant && bus.issue_ready;

  always_comb begin
    new_ent      = '0;
    new_ent.info = bus.dispatch_info;
    new_ent.ps1  = bus.dispatch_ps1;
    new_ent.ps2  = bus.dispatch_ps2;
    new_ent.pd   = bus.dispatch_pd;
    new_ent.rob  = bus.dispatch_rob;
    // Same-cycle CDB hit is folded in so the op is not left waiting forever.
    new_ent.rdy1 = bus.dispatch_ps1_rdy || (bus.dispatch_ps1 == '0) ||
                   (bus.cdb_valid && (bus.cdb_pd == bus.dispatch_ps1));
    new_ent.rdy2 = bus.dispatch_ps2_rdy || (bus.dispatch_ps2 == '0) ||
                   (bus.cdb_valid && (bus.cdb_pd == bus.dispatch_ps2));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
  end

`ifdef RS_ALU_OLDEST_FIRST_EN
  logic [DEPTH-1:0] age_q [DEPTH];

  // Writing slot s clears column s so a reused slot never looks older than its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) age_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) age_q[k] <= '0;
    end else if (dispatch_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (free_oh[k]) age_q[k] <= valid_q;
        else            age_q[k] <= age_q[k] & ~free_oh;
      end
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
    .cand      (cand),
    .age       (age_q),
    .grant     (grant),
    .any_grant (any_grant)
  );
`else
  rs_select #(.DEPTH(DEPTH)) u_select (
    .cand      (cand),
    .grant     (grant),
    .any_grant (any_grant)
  );
`endif

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_ent = ent_q[i];
    end
  end

  assign bus.issue_valid = any_grant;
  assign bus.issue_info  = sel_ent.info;
  assign bus.issue_ps1   = sel_ent.ps1;
  assign bus.issue_ps2   = sel_ent.ps2;
  assign bus.issue_pd    = sel_ent.pd;
  assign bus.issue_rob   = sel_ent.rob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch_fire && free_oh[i]) begin
          valid_q[i] <= 1'b1;
          ent_q[i]   <= new_ent;
        end else begin
          if (issue_fire && grant[i]) valid_q[i] <= 1'b0;
          if (bus.cdb_valid && valid_q[i]) begin
            if (ent_q[i].ps1 == bus.cdb_pd) ent_q[i].rdy1 <= 1'b1;
            if (ent_q[i].ps2 == bus.cdb_pd) ent_q[i].rdy2 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Directed table-driven bench for rs_alu plus hand sequences for ordering and async reset.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always #5 clk = ~clk;

  rs_alu_if #(.DEPTH(8), .PHYS_REG_BITS(6), .ROB_IDX_BITS(5)) bus ();

  rs_alu #(.DEPTH(8), .PHYS_REG_BITS(6), .ROB_IDX_BITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic       dv;
    logic [5:0] ps1;
    logic       r1;
    logic [5:0] ps2;
    logic       r2;
    logic [5:0] pd;
    logic       cv;
    logic [5:0] cpd;
    logic       ir;
    logic       fl;
    logic       e_iv;
    logic [5:0] e_pd;
    logic [3:0] e_occ;
    logic       e_dr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input int ps1, input logic r1,
                              input int ps2, input logic r2, input int pd,
                              input logic cv, input int cpd, input logic ir,
                              input logic fl, input logic e_iv, input int e_pd,
                              input int e_occ, input logic e_dr);
    vec_t v;
    v.dv = dv; v.ps1 = 6'(ps1); v.r1 = r1; v.ps2 = 6'(ps2); v.r2 = r2;
    v.pd = 6'(pd); v.cv = cv; v.cpd = 6'(cpd); v.ir = ir; v.fl = fl;
    v.e_iv = e_iv; v.e_pd = 6'(e_pd); v.e_occ = 4'(e_occ); v.e_dr = e_dr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk);
    bus.dispatch_valid   = v.dv;
    bus.dispatch_ps1     = v.ps1;
    bus.dispatch_ps1_rdy = v.r1;
    bus.dispatch_ps2     = v.ps2;
    bus.dispatch_ps2_rdy = v.r2;
    bus.dispatch_pd      = v.pd;
    bus.dispatch_rob     = v.pd[4:0];
    bus.cdb_valid        = v.cv;
    bus.cdb_pd           = v.cpd;
    bus.issue_ready      = v.ir;
    flush                = v.fl;
    #1;
    chk({tag, " issue_valid"}, int'(bus.issue_valid), int'(v.e_iv));
    chk({tag, " occupancy"}, int'(bus.occupancy), int'(v.e_occ));
    chk({tag, " dispatch_ready"}, int'(bus.dispatch_ready), int'(v.e_dr));
    if (v.e_iv) chk({tag, " issue_pd"}, int'(bus.issue_pd), int'(v.e_pd));
  endtask

  int first_pd;
  int second_pd;

  initial begin
    bus.dispatch_valid   = 1'b0;
    bus.dispatch_info    = '0;
    bus.dispatch_info.opcode = OPC_OP_IMM;
    bus.dispatch_ps1     = '0;
    bus.dispatch_ps2     = '0;
    bus.dispatch_ps1_rdy = 1'b0;
    bus.dispatch_ps2_rdy = 1'b0;
    bus.dispatch_pd      = '0;
    bus.dispatch_rob     = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_pd           = '0;
    bus.issue_ready      = 1'b0;

    // dv ps1 r1 ps2 r2 pd | cv cpd | ir fl | e_iv e_pd e_occ e_dr
    vecs.push_back(mk(1, 5, 1, 0, 0, 10, 0, 0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(1, 7, 0, 3, 1, 11, 0, 0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 7, 1, 0, 0,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 11, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 9, 0, 12, 1, 9, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 12, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 20 + k, 0, 0, 0, 30 + k, 0, 0, 1, 0, 0, 0, k, 1));
    vecs.push_back(mk(1, 40, 1, 0, 0, 50, 1, 23, 1, 0, 0,  0, 8, 0));
    vecs.push_back(mk(1, 40, 1, 0, 0, 50, 0,  0, 1, 0, 1, 33, 8, 0));
    vecs.push_back(mk(1, 40, 1, 0, 0, 50, 0,  0, 1, 0, 0,  0, 7, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 1, 50, 8, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0, 51, 0,  0, 0, 1, 1, 50, 8, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 60 + k, 0, 0, 0, 40 + k, 0, 0, 1, 0, 0, 0, k, 1));
    vecs.push_back(mk(1,  0, 1, 0, 1, 55, 0,  0, 1, 1, 0,  0, 4, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0,  0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(1,  0, 1, 0, 1, 60, 0,  0, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(1,  0, 1, 0, 1, 61, 0,  0, 1, 0, 1, 60, 1, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0,  0, 1, 0, 1, 61, 1, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0,  0, 1, 0, 0,  0, 0, 1));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Two ready entries, the older one sitting in the higher slot.
`ifdef RS_ALU_OLDEST_FIRST_EN
    first_pd = 2; second_pd = 3;
`else
    first_pd = 3; second_pd = 2;
`endif
    apply_vec("ord_a", mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    apply_vec("ord_b", mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 1, 1));
    apply_vec("ord_issue_a", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1));
    apply_vec("ord_c", mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 0, 1, 2, 1, 1));
    for (int k = 0; k < 3; k++) begin
      apply_vec($sformatf("hold%0d", k),
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, first_pd, 2, 1));
      chk($sformatf("hold%0d issue_rob", k), int'(bus.issue_rob), first_pd);
    end
    apply_vec("ord_first", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, first_pd, 2, 1));
    apply_vec("ord_second", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, second_pd, 1, 1));
    apply_vec("ord_empty", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset in the middle of a cycle with live entries.
    apply_vec("rst_d0", mk(1, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1));
    apply_vec("rst_d1", mk(1, 0, 1, 0, 1, 6, 0, 0, 0, 0, 1, 5, 1, 1));
    apply_vec("rst_pre", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 2, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst occupancy", int'(bus.occupancy), 0);
    chk("async_rst issue_valid", int'(bus.issue_valid), 0);
    chk("async_rst dispatch_ready", int'(bus.dispatch_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
